// File: rtl/spiflash_emu_if.sv
// rtl/spiflash_emu_if.sv - SPI pad and backing-memory signal bundle for spiflash_emu
interface spiflash_emu_if #(parameter int ADDR_BITS = 24);
  logic                 spi_csb;
  logic                 spi_clk;
  logic [3:0]           io_in;
  logic [3:0]           io_out;
  logic [3:0]           io_oe;
  logic [ADDR_BITS-1:0] mem_addr;
  logic                 mem_rd;
  logic [7:0]           mem_rdata;
  logic                 powered_up;
  logic                 xip_active;

  modport master (output spi_csb, spi_clk, io_in, mem_rdata,
                  input  io_out, io_oe, mem_addr, mem_rd, powered_up, xip_active);
  modport slave  (input  spi_csb, spi_clk, io_in, mem_rdata,
                  output io_out, io_oe, mem_addr, mem_rd, powered_up, xip_active);
endinterface

// File: rtl/spiflash_emu.sv
// rtl/spiflash_emu.sv - oversampling SPI flash slave emulator (single/dual/quad/XIP reads, JEDEC ID)
// Flash contents come from an external synchronous memory with one clk of read latency.
module spiflash_emu #(
  parameter int          ADDR_BITS = 24,
  parameter int          LATENCY   = 8,
  parameter logic [23:0] JEDEC_ID  = 24'hEF4018,
  parameter bit          POWER_ON  = 1'b0
) (
  input logic           clk,
  input logic           reset,
  spiflash_emu_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, MODE, DUMMY, DATA, ID} state_t;

  localparam logic [7:0] C_READ = 8'h03, C_FAST = 8'h0B, C_DUAL = 8'hBB, C_QUAD = 8'hEB;
  localparam logic [7:0] C_ID = 8'h9F, C_WAKE = 8'hAB, C_SLEEP = 8'hB9, C_XOFF = 8'hFF;
  localparam logic [7:0] XIP_KEY = 8'hA5;

  state_t               state, state_n;
  logic [1:0]           csb_sync;
  logic [2:0]           sclk_sync;
  logic [3:0]           io_s1, io_s2;
  logic                 csb_prev, load_pend;
  logic                 csb, rise, fall;
  logic [7:0]           cmd, cmd_n, xip_cmd, xip_cmd_n, sr_in, sr_in_n, dsr, dsr_n;
  logic [2:0]           bw, bw_n;
  logic [4:0]           bitcnt, bitcnt_n, bits_next;
  logic [1:0]           idx, idx_n;
  logic [15:0]          dcnt, dcnt_n;
  logic [23:0]          addr, addr_n;
  logic [3:0]           io_out_n, io_oe_n;
  logic [ADDR_BITS-1:0] mem_addr_n;
  logic                 mem_rd_n, powered_n, xip_n;

  function automatic logic [2:0] width_of(input logic [7:0] c);
    case (c)
      C_QUAD:  return 3'd4;
      C_DUAL:  return 3'd2;
      default: return 3'd1;
    endcase
  endfunction

  function automatic logic [7:0] shift_byte(input logic [7:0] v, input logic [3:0] p, input logic [2:0] w);
    case (w)
      3'd4:    return {v[3:0], p};
      3'd2:    return {v[5:0], p[1:0]};
      default: return {v[6:0], p[0]};
    endcase
  endfunction

  function automatic logic [23:0] shift_addr(input logic [23:0] v, input logic [3:0] p, input logic [2:0] w);
    case (w)
      3'd4:    return {v[19:0], p};
      3'd2:    return {v[21:0], p[1:0]};
      default: return {v[22:0], p[0]};
    endcase
  endfunction

  // Single-bit replies go out on io1, the conventional MISO pin.
  function automatic logic [3:0] out_pins(input logic [7:0] v, input logic [2:0] w);
    case (w)
      3'd4:    return v[7:4];
      3'd2:    return {2'b00, v[7:6]};
      default: return {2'b00, v[7], 1'b0};
    endcase
  endfunction

  function automatic logic [3:0] oe_for(input state_t s, input logic [2:0] w);
    if (s == ID) return 4'b0010;
    if (s != DATA) return 4'b0000;
    case (w)
      3'd4:    return 4'b1111;
      3'd2:    return 4'b0011;
      default: return 4'b0010;
    endcase
  endfunction

  function automatic logic [7:0] id_byte(input logic [1:0] i);
    case (i)
      2'd0:    return JEDEC_ID[23:16];
      2'd1:    return JEDEC_ID[15:8];
      default: return JEDEC_ID[7:0];
    endcase
  endfunction

  // io is taken from the same stage as sclk so each sample lines up with its edge.
  assign csb       = csb_sync[1];
  assign rise      = sclk_sync[1] & ~sclk_sync[2];
  assign fall      = ~sclk_sync[1] & sclk_sync[2];
  assign bits_next = bitcnt + {2'b00, bw};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csb_sync  <= 2'b11;
      sclk_sync <= 3'b000;
      io_s1     <= 4'b0;
      io_s2     <= 4'b0;
      csb_prev  <= 1'b1;
      load_pend <= 1'b0;
    end else begin
      csb_sync  <= {csb_sync[0], bus.spi_csb};
      sclk_sync <= {sclk_sync[1:0], bus.spi_clk};
      io_s1     <= bus.io_in;
      io_s2     <= io_s1;
      csb_prev  <= csb;
      load_pend <= bus.mem_rd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;  cmd <= 8'h00;  xip_cmd <= 8'h00;  sr_in <= 8'h00;  dsr <= 8'h00;
      bw <= 3'd1;  bitcnt <= 5'd0;  idx <= 2'd0;  dcnt <= 16'd0;  addr <= 24'd0;
      bus.io_out <= 4'b0;  bus.io_oe <= 4'b0;  bus.mem_addr <= '0;  bus.mem_rd <= 1'b0;
      bus.powered_up <= POWER_ON;  bus.xip_active <= 1'b0;
    end else begin
      state <= state_n;  cmd <= cmd_n;  xip_cmd <= xip_cmd_n;  sr_in <= sr_in_n;  dsr <= dsr_n;
      bw <= bw_n;  bitcnt <= bitcnt_n;  idx <= idx_n;  dcnt <= dcnt_n;  addr <= addr_n;
      bus.io_out <= io_out_n;  bus.io_oe <= io_oe_n;  bus.mem_addr <= mem_addr_n;  bus.mem_rd <= mem_rd_n;
      bus.powered_up <= powered_n;  bus.xip_active <= xip_n;
    end
  end

  always_comb begin
    state_n = state;  cmd_n = cmd;  xip_cmd_n = xip_cmd;  sr_in_n = sr_in;  dsr_n = dsr;
    bw_n = bw;  bitcnt_n = bitcnt;  idx_n = idx;  dcnt_n = dcnt;  addr_n = addr;
    io_out_n = bus.io_out;  mem_addr_n = bus.mem_addr;  mem_rd_n = 1'b0;
    powered_n = bus.powered_up;  xip_n = bus.xip_active;
    if (load_pend) dsr_n = bus.mem_rdata;
    // csb is checked first so an spi_clk edge racing csb rising is dropped.
    if (csb) begin
      state_n = IDLE;  bitcnt_n = 5'd0;  idx_n = 2'd0;  dcnt_n = 16'd0;
    end else if (csb_prev) begin
      bitcnt_n = 5'd0;
      if (bus.xip_active) begin
        cmd_n = xip_cmd;  bw_n = width_of(xip_cmd);  state_n = ADDR;
      end else begin
        bw_n = 3'd1;  state_n = CMD;
      end
    end else if (rise) begin
      case (state)
        CMD: begin
          sr_in_n  = shift_byte(sr_in, io_s2, bw);
          bitcnt_n = bits_next;
          if (bits_next == 5'd8) begin
            bitcnt_n = 5'd0;  cmd_n = sr_in_n;  state_n = IDLE;
            if (sr_in_n == C_WAKE) powered_n = 1'b1;
            else if (bus.powered_up) begin
              case (sr_in_n)
                C_SLEEP: powered_n = 1'b0;
                C_XOFF:  xip_n = 1'b0;
                C_READ, C_FAST, C_DUAL, C_QUAD: begin
                  bw_n = width_of(sr_in_n);  state_n = ADDR;
                end
                C_ID: begin
                  bw_n = 3'd1;  idx_n = 2'd0;  dsr_n = id_byte(2'd0);  state_n = ID;
                end
                default: ;
              endcase
            end
          end
        end
        ADDR: begin
          addr_n   = shift_addr(addr, io_s2, bw);
          bitcnt_n = bits_next;
          if (bits_next == 5'd24) begin
            bitcnt_n   = 5'd0;  dcnt_n = 16'd0;
            mem_addr_n = ADDR_BITS'(addr_n);
            mem_rd_n   = 1'b1;
            if (cmd == C_READ) state_n = DATA;
            else if (cmd == C_FAST) state_n = (LATENCY == 0) ? DATA : DUMMY;
            else state_n = MODE;
          end
        end
        MODE: begin
          sr_in_n  = shift_byte(sr_in, io_s2, bw);
          bitcnt_n = bits_next;
          if (bits_next == 5'd8) begin
            bitcnt_n  = 5'd0;
            xip_n     = (sr_in_n == XIP_KEY);
            if (sr_in_n == XIP_KEY) xip_cmd_n = cmd;
            state_n   = (LATENCY == 0) ? DATA : DUMMY;
          end
        end
        DUMMY: begin
          if (dcnt == 16'(LATENCY - 1)) begin
            dcnt_n = 16'd0;  state_n = DATA;
          end else dcnt_n = dcnt + 16'd1;
        end
        default: ;
      endcase
    end else if (fall && (state == DATA || state == ID)) begin
      io_out_n = out_pins(dsr, bw);
      dsr_n    = dsr << bw;
      bitcnt_n = bits_next;
      if (bits_next == 5'd8) begin
        bitcnt_n = 5'd0;
        if (state == ID) begin
          idx_n = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
          dsr_n = id_byte(idx_n);
        end else begin
          mem_addr_n = bus.mem_addr + ADDR_BITS'(1);
          mem_rd_n   = 1'b1;
        end
      end
    end
    io_oe_n = oe_for(state_n, bw_n);
  end
endmodule

// File: tb/tb_spiflash_emu.sv
// tb/tb_spiflash_emu.sv - randomized scoreboard bench for spiflash_emu
// Stimulus queues expected read bytes from a flash-level model; an SPI-side monitor pops and compares.
module tb_spiflash_emu;
  localparam int          ABITS = 24;
  localparam int          LAT   = 8;
  localparam logic [23:0] JID   = 24'hEF4018;
  localparam int          H     = 60;

  logic clk = 1'b0;
  logic reset = 1'b1;
  spiflash_emu_if #(.ADDR_BITS(ABITS)) bus ();
  spiflash_emu #(.ADDR_BITS(ABITS), .LATENCY(LAT), .JEDEC_ID(JID), .POWER_ON(1'b0))
    dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int tests = 0, fails = 0, rd_count = 0;
  logic [7:0] mem [logic [23:0]];
  logic [7:0] seed;
  logic [7:0] exp_q[$];
  logic [3:0] exp_oe = 4'b0;
  logic [7:0] acc = 8'h00;
  int nb = 0;
  bit m_powered = 1'b0, m_xip = 1'b0;
  logic [7:0] m_xip_cmd = 8'h00;

  function automatic logic [7:0] mem_get(input logic [23:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ seed;
  endfunction

  function automatic logic [7:0] jedec_byte(input int i);
    case (i % 3)
      0:       return JID[23:16];
      1:       return JID[15:8];
      default: return JID[7:0];
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (bus.mem_rd) begin
      bus.mem_rdata <= mem_get(bus.mem_addr);
      rd_count++;
    end
  end

  always @(posedge bus.spi_clk or posedge bus.spi_csb) begin
    if (bus.spi_csb) nb = 0;
    else begin
      check("io_oe", 32'(bus.io_oe), 32'(exp_oe));
      if (exp_oe != 4'b0) begin
        case (exp_oe)
          4'b1111: begin acc = {acc[3:0], bus.io_out};      nb += 4; end
          4'b0011: begin acc = {acc[5:0], bus.io_out[1:0]}; nb += 2; end
          default: begin acc = {acc[6:0], bus.io_out[1]};   nb += 1; end
        endcase
        if (nb == 8) begin
          nb = 0;
          if (exp_q.size() == 0) begin
            tests++;  fails++;
            $display("FAIL unexpected_byte: got %0h expected none", acc);
          end else check("data_byte", 32'(acc), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic clk_bits(input logic [3:0] pins, input logic [3:0] oe);
    bus.io_in = pins;  exp_oe = oe;
    #H bus.spi_clk = 1'b1;
    #H bus.spi_clk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int w);
    logic [7:0] v = b;
    for (int i = 0; i < 8 / w; i++) begin
      if (w == 4) clk_bits(v[7:4], 4'b0);
      else if (w == 2) clk_bits({2'b00, v[7:6]}, 4'b0);
      else clk_bits({3'b000, v[7]}, 4'b0);
      v = v << w;
    end
  endtask

  task automatic read_bytes(input logic [23:0] a, input int n, input int w);
    logic [3:0] oe = (w == 4) ? 4'b1111 : (w == 2) ? 4'b0011 : 4'b0010;
    for (int i = 0; i < n; i++) exp_q.push_back(mem_get(a + 24'(i)));
    repeat (n * 8 / w) clk_bits(4'b0, oe);
  endtask

  task automatic frame(input logic [7:0] c, input logic [23:0] a, input int n, input logic [7:0] mode);
    bit xf = m_xip;
    int w;
    if (xf) c = m_xip_cmd;
    bus.spi_csb = 1'b0;
    #H;
    if (!xf) send_byte(c, 1);
    if (!xf && c != 8'hAB && !m_powered) repeat (16) clk_bits(4'b0, 4'b0);
    else begin
      case (c)
        8'hAB: m_powered = 1'b1;
        8'hB9: m_powered = 1'b0;
        8'hFF: m_xip = 1'b0;
        8'h03: begin
          send_byte(a[23:16], 1);  send_byte(a[15:8], 1);  send_byte(a[7:0], 1);
          read_bytes(a, n, 1);
        end
        8'h0B: begin
          send_byte(a[23:16], 1);  send_byte(a[15:8], 1);  send_byte(a[7:0], 1);
          repeat (LAT) clk_bits(4'b0, 4'b0);
          read_bytes(a, n, 1);
        end
        8'hBB, 8'hEB: begin
          w = (c == 8'hEB) ? 4 : 2;
          send_byte(a[23:16], w);  send_byte(a[15:8], w);  send_byte(a[7:0], w);
          send_byte(mode, w);
          m_xip = (mode == 8'hA5);
          if (m_xip) m_xip_cmd = c;
          repeat (LAT) clk_bits(4'b0, 4'b0);
          read_bytes(a, n, w);
        end
        8'h9F: begin
          for (int i = 0; i < n; i++) exp_q.push_back(jedec_byte(i));
          repeat (n * 8) clk_bits(4'b0, 4'b0010);
        end
        default: repeat (16) clk_bits(4'b0, 4'b0);
      endcase
    end
    exp_oe = 4'b0;
    #H bus.spi_csb = 1'b1;
    #(3 * H);
    check("powered_up", 32'(bus.powered_up), 32'(m_powered));
    check("xip_active", 32'(bus.xip_active), 32'(m_xip));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    logic [7:0] c;
    logic [23:0] a;
    logic [7:0] md;
    seed = 8'($urandom);
    mem[24'h10] = 8'h11;  mem[24'h11] = 8'h22;  mem[24'h12] = 8'h33;  mem[24'h13] = 8'h44;
    for (int i = 0; i < 16; i++) mem[24'h100 + 24'(i)] = 8'($urandom);
    mem[24'hFFFFFF] = 8'($urandom);  mem[24'h000000] = 8'($urandom);
    bus.spi_csb = 1'b1;  bus.spi_clk = 1'b0;  bus.io_in = 4'b0;  bus.mem_rdata = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    check("rst_io_oe", 32'(bus.io_oe), 32'h0);
    check("rst_io_out", 32'(bus.io_out), 32'h0);
    check("rst_mem_rd", 32'(bus.mem_rd), 32'h0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    check("rst_powered", 32'(bus.powered_up), 32'h0);
    check("rst_xip", 32'(bus.xip_active), 32'h0);
    reset = 1'b0;
    #(2 * H);

    r0 = rd_count;
    frame(8'h03, 24'h10, 2, 8'h00);
    check("no_rd_unpowered", 32'(rd_count - r0), 32'h0);
    frame(8'hAB, 24'h0, 0, 8'h00);
    frame(8'h03, 24'h10, 4, 8'h00);
    frame(8'h9F, 24'h0, 4, 8'h00);
    frame(8'hEB, 24'h100, 4, 8'hA5);
    frame(8'h00, 24'h104, 3, 8'hA5);
    frame(8'h00, 24'h108, 2, 8'h00);
    frame(8'h0B, 24'hFFFFFF, 2, 8'h00);
    frame(8'hB9, 24'h0, 0, 8'h00);
    r0 = rd_count;
    frame(8'h03, 24'h10, 2, 8'h00);
    check("no_rd_asleep", 32'(rd_count - r0), 32'h0);
    frame(8'hAB, 24'h0, 0, 8'h00);

    for (int k = 0; k < 20; k++) begin
      case ($urandom_range(0, 9))
        0: c = 8'h03;  1: c = 8'h0B;  2: c = 8'hBB;  3: c = 8'hEB;  4: c = 8'h9F;
        5: c = 8'hAB;  6: c = 8'hB9;  7: c = 8'hFF;  8: c = 8'h5A;  default: c = 8'hEB;
      endcase
      a  = 24'($urandom);
      md = ($urandom_range(0, 1) == 1) ? 8'hA5 : 8'($urandom);
      frame(c, a, int'($urandom_range(1, 3)), md);
    end

    if (m_xip) frame(8'h00, 24'h20, 1, 8'h00);
    frame(8'hAB, 24'h0, 0, 8'h00);
    a = 24'h000200;
    bus.spi_csb = 1'b0;
    #H;
    send_byte(8'hBB, 1);
    send_byte(a[23:16], 2);  send_byte(a[15:8], 2);  send_byte(a[7:0], 2);
    send_byte(8'hA5, 2);
    repeat (LAT) clk_bits(4'b0, 4'b0);
    read_bytes(a, 1, 2);
    clk_bits(4'b0, 4'b0011);
    clk_bits(4'b0, 4'b0011);
    check("bb_xip_armed", 32'(bus.xip_active), 32'h1);
    check("bb_oe_data", 32'(bus.io_oe), 32'h3);
    reset = 1'b1;
    #1;
    check("rst_mid_oe", 32'(bus.io_oe), 32'h0);
    check("rst_mid_powered", 32'(bus.powered_up), 32'h0);
    check("rst_mid_xip", 32'(bus.xip_active), 32'h0);
    check("rst_mid_mem_rd", 32'(bus.mem_rd), 32'h0);
    exp_oe = 4'b0;
    bus.spi_csb = 1'b1;
    m_powered = 1'b0;  m_xip = 1'b0;
    #(H - 1);
    reset = 1'b0;
    #(2 * H);
    frame(8'h9F, 24'h0, 2, 8'h00);
    frame(8'hAB, 24'h0, 0, 8'h00);
    frame(8'h03, 24'h11, 3, 8'h00);

    check("scoreboard_drain", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/spiflash_emu.md
Name: spiflash_emu

Overview:
- Synthesizable SPI flash slave emulator for PicoSoC emulation/FPGA builds; successor to the behavioural flash model.
- Oversamples the SPI pins with the system clock. Decodes single, dual and quad read commands, including continuous-read (XIP) mode.
- Adds a fast-read command, a JEDEC ID read, and parametrised address width, dummy latency and ID.
- Flash contents live in an external synchronous ROM/RAM, accessed through a simple read port.

Parameters:
ADDR_BITS, 24, significant flash address bits; mem_addr width; upper command address bits ignored
LATENCY, 8, dummy SPI clocks for commands BB/EB after the mode byte, and for 0B after the address
JEDEC_ID, 24'hEF4018, 3-byte value returned by command 9F, MSB first
POWER_ON, 0, reset value of powered_up (1 = no AB wake-up needed)

Ports:
clk  in  1  system clock; must be ≥8× spi_clk frequency
reset  in  1  asynchronous, active-high reset
spi_csb  in  1  flash chip select, active low (asynchronous to clk)
spi_clk  in  1  SPI clock, mode 0 (asynchronous to clk)
io_in  in  4  pad inputs io3..io0
io_out  out  4  pad output data
io_oe  out  4  pad output enables
mem_addr  out  ADDR_BITS  byte address to backing memory
mem_rd  out  1  one-cycle read strobe
mem_rdata  in  8  read data, valid one clk after mem_rd
powered_up  out  1  device awake
xip_active  out  1  continuous-read mode armed

Behaviour:
- Reset values: io_out=0, io_oe=0, mem_rd=0, mem_addr=0, powered_up=POWER_ON, xip_active=0, state IDLE.
- Synchroniser: spi_csb, spi_clk and io_in each pass through a 2-flop synchroniser.
  - Rising and falling spi_clk edges are detected on the synchronised signal.
  - io_in is sampled from the same stage, so pad-to-sample alignment is preserved.
- Sampling and driving:
  - Input bits are captured on a detected rising edge.
  - Output bits update in the clk cycle after a detected falling edge.
  - Within one byte, bits are MSB first: 1 bit/edge (single), 2 bits (dual, io1:io0), 4 bits (quad, io3..io0).
- csb high (synchronised), any state: return to IDLE, io_oe=0, clear bit and byte counters. powered_up and xip_active are kept.
- csb falling edge:
  - xip_active=0: enter CMD.
  - xip_active=1: latch the stored command and enter ADDR directly in that command's width.
- States: IDLE, CMD, ADDR, MODE, DUMMY, DATA, ID.
- Commands (except AB, executed only when powered_up; others are ignored until csb rises):
  - AB: powered_up=1.
  - B9: powered_up=0.
  - FF: xip_active=0.
  - 03: single-bit ADDR(3 B), then DATA, no dummy.
  - 0B: single-bit ADDR, then DUMMY of LATENCY clocks, then DATA.
  - BB: dual ADDR, dual MODE byte, DUMMY, dual DATA.
  - EB: quad ADDR, quad MODE byte, DUMMY, quad DATA.
  - 9F: ID state shifts out JEDEC_ID single-bit, then repeats it.
- MODE byte: value 8'hA5 sets xip_active=1 and stores the command; any other value clears xip_active.
- ADDR completion: issue mem_rd with mem_addr equal to the address (truncated to ADDR_BITS). The shift register loads mem_rdata before the next falling edge.
- DATA: after each byte, mem_addr increments and mem_rd pulses. The address wraps from 2^ADDR_BITS−1 to 0.
- Output enables:
  - Single-bit DATA/ID: io_oe=4'b0010.
  - Dual DATA: 4'b0011.
  - Quad DATA: 4'b1111.
  - DUMMY, CMD, ADDR and MODE: 4'b0000.
- Unknown command byte: ignore all edges until csb rises; io_oe stays 0.
- spi_clk edge coincident with csb rising: csb wins and no bit is captured.
- reset asserted mid-transfer: immediately return to reset values, including powered_up=POWER_ON.

Test Plan:
- AB, then 03 at addr 0x000010, mem[0x10..0x13]=11 22 33 44 → io1 returns 0x11,0x22,0x33,0x44; io_oe=0010 only during data.
- 9F with powered_up=1 → 0xEF,0x40,0x18, then 0xEF again on the 4th byte.
- EB at addr 0x000100, mode 0xA5, 8 dummy clocks → quad data mem[0x100]...; xip_active=1.
  - Next csb frame sends address only and returns data with the same latency.
  - A further frame with mode 0x00 → xip_active=0.
- 0B at addr 0xFFFFFF with ADDR_BITS=24 → bytes mem[0xFFFFFF] then mem[0x000000] (wrap).
- 03 without prior AB (POWER_ON=0) → io_oe stays 0, no mem_rd; after B9, 03 is again ignored.
- Assert reset during BB data phase → io_oe=0 in the same cycle, powered_up=POWER_ON, xip_active=0; the next frame decodes a fresh command.
